// File: rtl/case_3_sdiv_8s_4s_8_seq.sv
// Sequential restoring signed divider: N-bit dividend by M-bit divisor, one quotient bit per edge.
// Optional err output is enabled by defining SDIV_ERR_FLAG_EN.
module case_3_sdiv_8s_4s_8_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  idle,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
`ifdef SDIV_ERR_FLAG_EN
    output logic [din1_WIDTH-1:0] rem,
    output logic                  err
`else
    output logic [din1_WIDTH-1:0] rem
`endif
);

    localparam int N  = din0_WIDTH;
    localparam int M  = din1_WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dvd;
    logic [M-1:0]  dvs;
    logic [M-1:0]  pr;
    logic [N-1:0]  q;
    logic          sq;
    logic          sr;
    logic          dz;
    logic [M-1:0]  lo;

    logic          last;
    logic          accept;
    logic [N-1:0]  mag0;
    logic [M-1:0]  mag1;
    logic [M:0]    sh;
    logic [M:0]    diff;
    logic          qb;
    logic [M-1:0]  pr_nx;
    logic [N-1:0]  q_nx;
    logic [N-1:0]  q_fin;
    logic [M-1:0]  r_fin;

    assign idle   = (state == S_IDLE) || (state == S_DONE);
    assign done   = (state == S_DONE);
    assign last   = (cnt == CW'(1));
    assign accept = idle && start;

    // An N-bit unsigned magnitude already holds 2^(N-1), so -2^(N-1) is lossless.
    assign mag0 = din0[N-1] ? -din0 : din0;
    assign mag1 = din1[M-1] ? -din1 : din1;

    always_comb begin
        sh    = {pr, dvd[N-1]};
        diff  = sh - {1'b0, dvs};
        qb    = ~diff[M];
        pr_nx = qb ? diff[M-1:0] : sh[M-1:0];
        q_nx  = {q[N-2:0], qb};
        q_fin = sq ? -q_nx : q_nx;
        r_fin = sr ? -pr_nx : pr_nx;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ce) begin
            unique case (state)
                S_IDLE:  if (start) state_nx = S_CALC;
                S_CALC:  if (last) state_nx = S_DONE;
                S_DONE:  state_nx = start ? S_CALC : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

`ifdef SDIV_ERR_FLAG_EN
    logic ovf;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            pr   <= '0;
            q    <= '0;
            sq   <= 1'b0;
            sr   <= 1'b0;
            dz   <= 1'b0;
            lo   <= '0;
            dout <= '0;
            rem  <= '0;
`ifdef SDIV_ERR_FLAG_EN
            ovf  <= 1'b0;
            err  <= 1'b0;
`endif
        end else if (ce) begin
            if (accept) begin
                cnt <= CW'(N);
                dvd <= mag0;
                dvs <= mag1;
                pr  <= '0;
                q   <= '0;
                sq  <= din0[N-1] ^ din1[M-1];
                sr  <= din0[N-1];
                dz  <= (din1 == '0);
                lo  <= din0[M-1:0];
`ifdef SDIV_ERR_FLAG_EN
                ovf <= (din0 == {1'b1, {(N-1){1'b0}}}) && (din1 == '1);
`endif
            end else if (state == S_CALC) begin
                cnt <= cnt - CW'(1);
                dvd <= dvd << 1;
                pr  <= pr_nx;
                q   <= q_nx;
                if (last) begin
                    dout <= dz ? '1 : q_fin;
                    rem  <= dz ? lo : r_fin;
`ifdef SDIV_ERR_FLAG_EN
                    err  <= dz | ovf;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_case_3_sdiv_8s_4s_8_seq.sv
// Directed bench for the sequential signed divider.
// Checks latency, signs, error cases, back-to-back, ce stall and reset abort.
module tb_case_3_sdiv_8s_4s_8_seq;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b1;
    logic              start = 1'b0;
    logic signed [7:0] din0 = '0;
    logic signed [3:0] din1 = '0;
    logic              idle;
    logic              done;
    logic [7:0]        dout;
    logic [3:0]        rem;
`ifdef SDIV_ERR_FLAG_EN
    logic              err;
`endif

    int total = 0;
    int bad = 0;
    logic saw;

    case_3_sdiv_8s_4s_8_seq dut (
        .ap_clk(clk),
        .ap_rst_n(rst_n),
        .ce(ce),
        .start(start),
        .din0(din0),
        .din1(din1),
        .idle(idle),
        .done(done),
        .dout(dout),
`ifdef SDIV_ERR_FLAG_EN
        .rem(rem),
        .err(err)
`else
        .rem(rem)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input logic e);
`ifdef SDIV_ERR_FLAG_EN
        chk("err", {31'b0, err}, {31'b0, e});
`else
        if (e === 1'bx) $display("unused");
`endif
    endtask

    task automatic go(input int a, input int b);
        din0  = 8'(a);
        din1  = 4'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish(input int pre, input int qe, input int re, input logic e);
        repeat (pre) tick();
        chk("early_done", {31'b0, done}, 0);
        tick();
        chk("done", {31'b0, done}, 1);
        chk("dout", $signed(dout), qe);
        chk("rem", $signed(rem), re);
        chk_err(e);
    endtask

    task automatic run(input int a, input int b, input int qe, input int re, input logic e);
        go(a, b);
        finish(7, qe, re, e);
        tick();
        chk("done_drop", {31'b0, done}, 0);
        chk("idle_after", {31'b0, idle}, 1);
    endtask

    initial begin
        #1;
        chk("rst_idle", {31'b0, idle}, 1);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_dout", $signed(dout), 0);
        chk("rst_rem", $signed(rem), 0);
        chk_err(1'b0);
        #11 rst_n = 1'b1;
        tick();

        run(100, 7, 14, 2, 1'b0);
        run(-100, 7, -14, -2, 1'b0);
        run(100, -7, -14, 2, 1'b0);
        run(-100, -7, 14, -2, 1'b0);
        run(-128, 7, -18, -2, 1'b0);
        run(7, -8, 0, 7, 1'b0);
        run(-128, -1, -128, 0, 1'b1);
        run(5, 0, -1, 5, 1'b1);

        // back-to-back from DONE, with a start pulse ignored during CALC
        go(100, 7);
        finish(7, 14, 2, 1'b0);
        go(127, 3);
        chk("b2b_done_drop", {31'b0, done}, 0);
        chk("b2b_busy", {31'b0, idle}, 0);
        tick();
        go(1, 1);
        finish(5, 42, 1, 1'b0);
        tick();

        // ce stall mid-CALC, then ce stall on the done cycle
        go(100, 7);
        repeat (3) tick();
        ce = 1'b0;
        repeat (3) tick();
        ce = 1'b1;
        finish(4, 14, 2, 1'b0);
        ce = 1'b0;
        repeat (2) tick();
        chk("ce_done_held", {31'b0, done}, 1);
        chk("ce_dout_held", $signed(dout), 14);
        ce = 1'b1;
        tick();
        chk("ce_done_drop", {31'b0, done}, 0);

        // reset abort during CALC
        go(77, 5);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_dout", $signed(dout), 0);
        chk("abort_rem", $signed(rem), 0);
        chk("abort_idle", {31'b0, idle}, 1);
        chk("abort_done", {31'b0, done}, 0);
        #2 rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) saw = 1'b1;
        end
        chk("abort_no_done", {31'b0, saw}, 0);
        run(50, 6, 8, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
